// File: rtl/pipe_pkg.sv
// Shared ID/EX pipeline types: register/operand widths, the captured record,
// the per-edge stage action and the load-use hazard predicate.
package pipe_pkg;

  localparam int unsigned REG_AW = 6;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 8;

  localparam logic [REG_AW-1:0] NULL_REG = '0;

  typedef struct packed {
    logic [REG_AW-1:0] ra;
    logic [REG_AW-1:0] rb;
    logic [REG_AW-1:0] rf;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [CTRL_W-1:0] ctrl;
    logic              reg_write;
    logic              mem_read;
  } id_ex_t;

  typedef enum logic [1:0] {
    ACT_CAPTURE,
    ACT_HOLD,
    ACT_BUBBLE
  } stage_act_t;

  // Register 0 is hardwired to zero, so a load targeting it is never a hazard.
  function automatic logic is_load_use(
    input logic              valid_ex,
    input logic              mem_read_ex,
    input logic              reg_write_ex,
    input logic              in_valid,
    input logic [REG_AW-1:0] ra_id,
    input logic [REG_AW-1:0] rb_id,
    input logic [REG_AW-1:0] rf_ex
  );
    return valid_ex & mem_read_ex & reg_write_ex & in_valid &
           (rf_ex != NULL_REG) & ((ra_id == rf_ex) | (rb_id == rf_ex));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that increments on enable and sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, EX-busy hold,
// IF/ID stall request and a saturating bubble counter.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [REG_AW-1:0] ra_id,
  input  logic [REG_AW-1:0] rb_id,
  input  logic [REG_AW-1:0] rf_id,
  input  logic [DATA_W-1:0] op_a_id,
  input  logic [DATA_W-1:0] op_b_id,
  input  logic [CTRL_W-1:0] ctrl_id,
  input  logic              reg_write_id,
  input  logic              mem_read_id,
  input  logic              flush,
  input  logic              ex_busy,
  output logic              valid_ex,
  output logic [REG_AW-1:0] ra_ex,
  output logic [REG_AW-1:0] rb_ex,
  output logic [REG_AW-1:0] rf_ex,
  output logic [DATA_W-1:0] op_a_ex,
  output logic [DATA_W-1:0] op_b_ex,
  output logic [CTRL_W-1:0] ctrl_ex,
  output logic              reg_write_ex,
  output logic              mem_read_ex,
  output logic              stall_if_id,
  output logic [CNT_W-1:0]  bubble_count
);

  id_ex_t     stage_q;
  id_ex_t     incoming;
  logic       valid_q;
  logic       load_use;
  stage_act_t act;

  assign load_use = is_load_use(valid_q, stage_q.mem_read, stage_q.reg_write,
                                in_valid, ra_id, rb_id, stage_q.rf);

  assign stall_if_id = ~flush & (ex_busy | load_use);

  // Flush outranks hold, hold outranks the hazard (re-checked once EX frees up).
  always_comb begin
    act = ACT_CAPTURE;
    if (flush) begin
      act = ACT_BUBBLE;
    end else if (ex_busy) begin
      act = ACT_HOLD;
    end else if (load_use) begin
      act = ACT_BUBBLE;
    end
  end

  always_comb begin
    incoming           = '0;
    incoming.ra        = ra_id;
    incoming.rb        = rb_id;
    incoming.rf        = rf_id;
    incoming.op_a      = op_a_id;
    incoming.op_b      = op_b_id;
    incoming.ctrl      = ctrl_id;
    incoming.reg_write = reg_write_id;
    incoming.mem_read  = mem_read_id;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      stage_q <= '0;
    end else begin
      case (act)
        ACT_BUBBLE: begin
          valid_q <= 1'b0;
          stage_q <= '0;
        end
        ACT_HOLD: begin
          valid_q <= valid_q;
          stage_q <= stage_q;
        end
        default: begin
          valid_q <= in_valid;
          stage_q <= in_valid ? incoming : '0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (act == ACT_BUBBLE),
    .count (bubble_count)
  );

  assign valid_ex     = valid_q;
  assign ra_ex        = stage_q.ra;
  assign rb_ex        = stage_q.rb;
  assign rf_ex        = stage_q.rf;
  assign op_a_ex      = stage_q.op_a;
  assign op_b_ex      = stage_q.op_b;
  assign ctrl_ex      = stage_q.ctrl;
  assign reg_write_ex = stage_q.reg_write & valid_q;
  assign mem_read_ex  = stage_q.mem_read & valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage (built with a 4-bit bubble counter).
module tb_id_ex_stage;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;
  localparam int unsigned NW = 4;
  localparam int CNT_MAX = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [AW-1:0] ra_id, rb_id, rf_id;
  logic [DW-1:0] op_a_id, op_b_id;
  logic [CW-1:0] ctrl_id;
  logic          reg_write_id, mem_read_id, flush, ex_busy;
  logic          valid_ex;
  logic [AW-1:0] ra_ex, rb_ex, rf_ex;
  logic [DW-1:0] op_a_ex, op_b_ex;
  logic [CW-1:0] ctrl_ex;
  logic          reg_write_ex, mem_read_ex, stall_if_id;
  logic [NW-1:0] bubble_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.CNT_W(NW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .ra_id        (ra_id),
    .rb_id        (rb_id),
    .rf_id        (rf_id),
    .op_a_id      (op_a_id),
    .op_b_id      (op_b_id),
    .ctrl_id      (ctrl_id),
    .reg_write_id (reg_write_id),
    .mem_read_id  (mem_read_id),
    .flush        (flush),
    .ex_busy      (ex_busy),
    .valid_ex     (valid_ex),
    .ra_ex        (ra_ex),
    .rb_ex        (rb_ex),
    .rf_ex        (rf_ex),
    .op_a_ex      (op_a_ex),
    .op_b_ex      (op_b_ex),
    .ctrl_ex      (ctrl_ex),
    .reg_write_ex (reg_write_ex),
    .mem_read_ex  (mem_read_ex),
    .stall_if_id  (stall_if_id),
    .bubble_count (bubble_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input int ra, input int rb, input int rf,
                       input logic [DW-1:0] opa, input logic rw, input logic mr,
                       input logic fl, input logic busy);
    in_valid     = v;
    ra_id        = AW'(ra);
    rb_id        = AW'(rb);
    rf_id        = AW'(rf);
    op_a_id      = opa;
    op_b_id      = opa ^ 32'hFFFF_0000;
    ctrl_id      = opa[7:0] ^ 8'h5A;
    reg_write_id = rw;
    mem_read_id  = mr;
    flush        = fl;
    ex_busy      = busy;
  endtask

  // Reference model: architectural content of the EX slot.
  typedef struct {
    bit          valid;
    int          ra, rb, rf;
    logic [DW-1:0] opa, opb;
    logic [CW-1:0] ctrl;
    bit          rw, mr;
    int          cnt;
  } model_t;
  model_t m;

  function automatic bit model_hazard();
    return m.valid && m.mr && m.rw && in_valid && m.rf != 0 &&
           (int'(ra_id) == m.rf || int'(rb_id) == m.rf);
  endfunction

  function automatic bit model_stall();
    return !flush && (ex_busy || model_hazard());
  endfunction

  task automatic model_clear();
    m.valid = 0; m.ra = 0; m.rb = 0; m.rf = 0;
    m.opa = '0; m.opb = '0; m.ctrl = '0; m.rw = 0; m.mr = 0;
  endtask

  task automatic model_edge();
    bit haz;
    haz = model_hazard();
    if (flush || (!ex_busy && haz)) begin
      model_clear();
      if (m.cnt < CNT_MAX) m.cnt++;
    end else if (!ex_busy) begin
      if (in_valid) begin
        m.valid = 1; m.ra = int'(ra_id); m.rb = int'(rb_id); m.rf = int'(rf_id);
        m.opa = op_a_id; m.opb = op_b_id; m.ctrl = ctrl_id;
        m.rw = reg_write_id; m.mr = mem_read_id;
      end else begin
        model_clear();
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid_ex"}, 64'(valid_ex), 64'(m.valid));
    chk({tag, ".ra_ex"}, 64'(ra_ex), 64'(m.ra));
    chk({tag, ".rb_ex"}, 64'(rb_ex), 64'(m.rb));
    chk({tag, ".rf_ex"}, 64'(rf_ex), 64'(m.rf));
    chk({tag, ".op_a_ex"}, 64'(op_a_ex), 64'(m.opa));
    chk({tag, ".op_b_ex"}, 64'(op_b_ex), 64'(m.opb));
    chk({tag, ".ctrl_ex"}, 64'(ctrl_ex), 64'(m.ctrl));
    chk({tag, ".reg_write_ex"}, 64'(reg_write_ex), 64'(m.rw));
    chk({tag, ".mem_read_ex"}, 64'(mem_read_ex), 64'(m.mr));
    chk({tag, ".bubble_count"}, 64'(bubble_count), 64'(m.cnt));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, '0, 0, 0, 0, 0);
    model_clear();
    m.cnt = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit v; int ra, rb, rf; logic [DW-1:0] opa; bit rw, mr, fl, busy;
    bit e_stall, e_valid; int e_ra, e_rf; logic [DW-1:0] e_opa; bit e_rw, e_mr; int e_cnt;
  } vec_t;

  vec_t vecs[15];

  initial begin
    // {v ra rb rf opa rw mr fl busy | stall valid ra rf opa rw mr cnt}
    vecs[0]  = '{1,3,4,5,32'h10,1,0,0,0, 0,1,3,5,32'h10,1,0,0};
    vecs[1]  = '{1,1,2,7,32'h30,1,1,0,0, 0,1,1,7,32'h30,1,1,0};
    vecs[2]  = '{1,7,0,8,32'h40,1,0,0,0, 1,0,0,0,32'h0,0,0,1};
    vecs[3]  = '{1,7,0,8,32'h40,1,0,0,0, 0,1,7,8,32'h40,1,0,1};
    vecs[4]  = '{1,2,3,0,32'h50,1,1,0,0, 0,1,2,0,32'h50,1,1,1};
    vecs[5]  = '{1,0,0,9,32'h60,1,0,0,0, 0,1,0,9,32'h60,1,0,1};
    vecs[6]  = '{1,1,1,7,32'h70,1,0,0,0, 0,1,1,7,32'h70,1,0,1};
    vecs[7]  = '{1,2,7,3,32'h80,1,0,0,0, 0,1,2,3,32'h80,1,0,1};
    vecs[8]  = '{0,5,5,6,32'h88,1,1,0,0, 0,0,0,0,32'h0,0,0,1};
    vecs[9]  = '{1,1,1,7,32'h90,1,1,0,0, 0,1,1,7,32'h90,1,1,1};
    vecs[10] = '{1,7,0,2,32'h95,1,0,1,0, 0,0,0,0,32'h0,0,0,2};
    vecs[11] = '{1,4,4,7,32'hA0,1,1,0,0, 0,1,4,7,32'hA0,1,1,2};
    vecs[12] = '{1,0,7,2,32'hA5,1,0,1,1, 0,0,0,0,32'h0,0,0,3};
    vecs[13] = '{1,4,4,7,32'hB0,1,1,0,0, 0,1,4,7,32'hB0,1,1,3};
    vecs[14] = '{0,7,7,2,32'hB5,1,0,0,0, 0,0,0,0,32'h0,0,0,3};

    // Reset with random inputs toggling.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 63), $urandom_range(0, 63),
            $urandom_range(0, 63), $urandom, 1, 1, 0, 0);
      @(posedge clk); #1;
    end
    chk("reset.valid_ex", 64'(valid_ex), 0);
    chk("reset.ra_rb_rf", {46'(0), ra_ex, rb_ex, rf_ex}, 0);
    chk("reset.operands", {op_a_ex, op_b_ex}, 0);
    chk("reset.ctrl_flags", {54'(0), ctrl_ex, reg_write_ex, mem_read_ex}, 0);
    chk("reset.bubble_count", 64'(bubble_count), 0);
    drive(0, 0, 0, 0, '0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].v, vecs[i].ra, vecs[i].rb, vecs[i].rf, vecs[i].opa,
            vecs[i].rw, vecs[i].mr, vecs[i].fl, vecs[i].busy);
      #1;
      chk($sformatf("vec%0d.stall", i), 64'(stall_if_id), 64'(vecs[i].e_stall));
      @(posedge clk); #1;
      chk($sformatf("vec%0d.valid", i), 64'(valid_ex), 64'(vecs[i].e_valid));
      chk($sformatf("vec%0d.ra", i), 64'(ra_ex), 64'(vecs[i].e_ra));
      chk($sformatf("vec%0d.rf", i), 64'(rf_ex), 64'(vecs[i].e_rf));
      chk($sformatf("vec%0d.op_a", i), 64'(op_a_ex), 64'(vecs[i].e_opa));
      chk($sformatf("vec%0d.rw_mr", i), {62'(0), reg_write_ex, mem_read_ex},
          {62'(0), vecs[i].e_rw, vecs[i].e_mr});
      chk($sformatf("vec%0d.cnt", i), 64'(bubble_count), 64'(vecs[i].e_cnt));
    end

    // Hold for 4 cycles while ID inputs change.
    do_reset();
    drive(1, 3, 4, 5, 32'h11, 1, 0, 0, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      drive(1, $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63),
            $urandom, 1, 1, 0, 1);
      #1;
      chk("hold.stall", 64'(stall_if_id), 1);
      @(posedge clk); #1;
      chk("hold.valid", 64'(valid_ex), 1);
      chk("hold.regs", {46'(0), ra_ex, rb_ex, rf_ex}, {46'(0), 6'd3, 6'd4, 6'd5});
      chk("hold.op_a", 64'(op_a_ex), 64'h11);
      chk("hold.cnt", 64'(bubble_count), 0);
    end

    // Hold outranks a pending load-use; the hazard resolves after the hold.
    drive(1, 1, 2, 7, 32'h22, 1, 1, 0, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      drive(1, 7, 0, 9, 32'h33, 1, 0, 0, 1);
      #1;
      chk("busy_lu.stall", 64'(stall_if_id), 1);
      @(posedge clk); #1;
      chk("busy_lu.rf", 64'(rf_ex), 7);
      chk("busy_lu.cnt", 64'(bubble_count), 0);
    end
    drive(1, 7, 0, 9, 32'h33, 1, 0, 0, 0);
    #1;
    chk("busy_lu.stall_after", 64'(stall_if_id), 1);
    @(posedge clk); #1;
    chk("busy_lu.bubble_valid", 64'(valid_ex), 0);
    chk("busy_lu.bubble_cnt", 64'(bubble_count), 1);
    #1;
    chk("busy_lu.stall_released", 64'(stall_if_id), 0);
    @(posedge clk); #1;
    chk("busy_lu.dep_ra", 64'(ra_ex), 7);
    chk("busy_lu.dep_valid", 64'(valid_ex), 1);

    // Asynchronous reset in the middle of a hold.
    drive(1, 12, 13, 14, 32'h44, 1, 0, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset.valid", 64'(valid_ex), 0);
    chk("midreset.rf", 64'(rf_ex), 0);
    chk("midreset.cnt", 64'(bubble_count), 0);
    #2 rst_n = 1'b1;
    drive(1, 2, 3, 6, 32'h55, 1, 0, 0, 0);
    @(posedge clk); #1;
    chk("midreset.capture_valid", 64'(valid_ex), 1);
    chk("midreset.capture_rf", 64'(rf_ex), 6);

    // Saturation: 18 consecutive flushes on a 4-bit counter.
    do_reset();
    for (int i = 1; i <= 18; i++) begin
      drive(1, 1, 1, 1, 32'h1, 1, 1, 1, 0);
      @(posedge clk); #1;
      chk($sformatf("sat.cnt%0d", i), 64'(bubble_count), 64'((i < CNT_MAX) ? i : CNT_MAX));
    end

    // Randomized run against the reference model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom, $urandom_range(0, 3) != 0,
            $urandom_range(0, 1), $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0);
      #1;
      chk("rand.stall", 64'(stall_if_id), 64'(model_stall()));
      @(posedge clk);
      model_edge();
      #1;
      check_all("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
